// File: rtl/calc_controller.sv
`default_nettype none
// ============================================================================
// Module      : calc_controller
// Description : Multi-cycle 8-bit calculator. It performs add, subtract,
//               multiply or restoring divide on two latched operands. It then
//               converts the 8-bit result to BCD using shift-add-3, and
//               presents the digits together with Zero/Overflow flags and a
//               one-cycle Done pulse.
// Ports       :
//   clock                 - single clock, rising edge
//   reset                 - asynchronous, active-low reset
//   Clear                 - synchronous abort, returns to IDLE with reset values
//   Start                 - compute request, accepted only in IDLE
//   Op[1:0]               - 00 add, 01 sub (A-B), 10 mul, 11 div (A/B)
//   OperandA/OperandB     - unsigned 8-bit operands
//   Busy                  - high whenever the FSM is not in IDLE
//   Done                  - one-cycle pulse when a new result is presented
//   Units/Tens[3:0]       - BCD digits of the result
//   Hundreds[1:0]         - hundreds digit, 0..2
//   Zero                  - result is 0 and did not overflow
//   Overflow              - result not representable in 0..255
// Revision    : 1.0 - initial release
// ============================================================================
module calc_controller #(
    parameter int reg_delay = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Clear,
    input  logic       Start,
    input  logic [1:0] Op,
    input  logic [7:0] OperandA,
    input  logic [7:0] OperandB,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] Units,
    output logic [3:0] Tens,
    output logic [1:0] Hundreds,
    output logic       Zero,
    output logic       Overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CALC    = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [3:0] c_DIV_LAST = 4'd7;
    localparam logic [3:0] c_BCD_STEPS = 4'd8;

    // The register-update delay only exists for behavioural models; this
    // implementation is zero-delay, so the parameter is intentionally unused.
    logic w_unused_delay;
    assign w_unused_delay = (reg_delay != 0);

    state_t     r_state;
    logic [1:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_result;
    logic       r_ovf;
    logic [7:0] r_rem;
    logic [7:0] r_quo;
    logic [3:0] r_cnt;
    logic [7:0] r_bin;
    logic [1:0] r_bcd_h;
    logic [3:0] r_bcd_t;
    logic [3:0] r_bcd_u;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_units;
    logic [3:0] r_tens;
    logic [1:0] r_hund;
    logic       r_zero;
    logic       r_overflow;

    // ---------------- single-cycle arithmetic ----------------
    logic [8:0]  w_sum;
    logic [7:0]  w_diff;
    logic [15:0] w_prod;
    logic [7:0]  w_calc_res;
    logic        w_calc_ovf;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = r_a - r_b;
    assign w_prod = {8'd0, r_a} * {8'd0, r_b};

    always_comb begin
        w_calc_res = w_sum[7:0];
        w_calc_ovf = w_sum[8];
        case (r_op)
            c_OP_ADD: begin
                w_calc_res = w_sum[7:0];
                w_calc_ovf = w_sum[8];
            end
            c_OP_SUB: begin
                w_calc_res = w_diff;
                w_calc_ovf = (r_b > r_a);
            end
            c_OP_MUL: begin
                w_calc_res = w_prod[7:0];
                w_calc_ovf = (w_prod[15:8] != 8'd0);
            end
            default: begin
                w_calc_res = w_sum[7:0];
                w_calc_ovf = w_sum[8];
            end
        endcase
    end

    // ---------------- restoring division step ----------------
    // The partial remainder is always < B <= 255, so the shifted trial value
    // fits in 9 bits and the restored remainder fits back into 8 bits.
    logic [8:0] w_div_sh;
    logic       w_div_ge;
    logic [7:0] w_rem_nxt;
    logic [7:0] w_quo_nxt;

    assign w_div_sh  = {r_rem, r_quo[7]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
    assign w_rem_nxt = w_div_ge ? (w_div_sh[7:0] - r_b) : w_div_sh[7:0];
    assign w_quo_nxt = {r_quo[6:0], w_div_ge};

    // ---------------- shift-add-3 step ----------------
    // Hundreds never reaches 5 for an 8-bit value, so it needs no correction.
    logic [3:0] w_u_adj;
    logic [3:0] w_t_adj;

    assign w_u_adj = (r_bcd_u >= 4'd5) ? (r_bcd_u + 4'd3) : r_bcd_u;
    assign w_t_adj = (r_bcd_t >= 4'd5) ? (r_bcd_t + 4'd3) : r_bcd_t;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op       <= 2'd0;
            r_a        <= 8'd0;
            r_b        <= 8'd0;
            r_result   <= 8'd0;
            r_ovf      <= 1'b0;
            r_rem      <= 8'd0;
            r_quo      <= 8'd0;
            r_cnt      <= 4'd0;
            r_bin      <= 8'd0;
            r_bcd_h    <= 2'd0;
            r_bcd_t    <= 4'd0;
            r_bcd_u    <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_units    <= 4'd0;
            r_tens     <= 4'd0;
            r_hund     <= 2'd0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
        end else if (Clear) begin
            r_state    <= S_IDLE;
            r_op       <= 2'd0;
            r_a        <= 8'd0;
            r_b        <= 8'd0;
            r_result   <= 8'd0;
            r_ovf      <= 1'b0;
            r_rem      <= 8'd0;
            r_quo      <= 8'd0;
            r_cnt      <= 4'd0;
            r_bin      <= 8'd0;
            r_bcd_h    <= 2'd0;
            r_bcd_t    <= 4'd0;
            r_bcd_u    <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_units    <= 4'd0;
            r_tens     <= 4'd0;
            r_hund     <= 2'd0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_op    <= Op;
                        r_a     <= OperandA;
                        r_b     <= OperandB;
                        r_quo   <= OperandA;
                        r_rem   <= 8'd0;
                        r_cnt   <= 4'd0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end

                S_CALC: begin
                    if (r_op != 2'b11) begin
                        r_result <= w_calc_res;
                        r_bin    <= w_calc_res;
                        r_ovf    <= w_calc_ovf;
                        r_cnt    <= 4'd0;
                        r_bcd_h  <= 2'd0;
                        r_bcd_t  <= 4'd0;
                        r_bcd_u  <= 4'd0;
                        r_state  <= S_CONVERT;
                    end else if ((r_cnt == 4'd0) && (r_b == 8'd0)) begin
                        // Divide by zero: skip the iterations entirely.
                        r_ovf   <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= S_CONVERT;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_cnt == c_DIV_LAST) begin
                            r_result <= w_quo_nxt;
                            r_bin    <= w_quo_nxt;
                            r_cnt    <= 4'd0;
                            r_bcd_h  <= 2'd0;
                            r_bcd_t  <= 4'd0;
                            r_bcd_u  <= 4'd0;
                            r_state  <= S_CONVERT;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end

                S_CONVERT: begin
                    if (r_ovf) begin
                        r_units    <= 4'd0;
                        r_tens     <= 4'd0;
                        r_hund     <= 2'd0;
                        r_zero     <= 1'b0;
                        r_overflow <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (r_cnt == c_BCD_STEPS) begin
                        r_units    <= r_bcd_u;
                        r_tens     <= r_bcd_t;
                        r_hund     <= r_bcd_h;
                        r_zero     <= (r_result == 8'd0);
                        r_overflow <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_bcd_h <= {r_bcd_h[0], w_t_adj[3]};
                        r_bcd_t <= {w_t_adj[2:0], w_u_adj[3]};
                        r_bcd_u <= {w_u_adj[2:0], r_bin[7]};
                        r_bin   <= {r_bin[6:0], 1'b0};
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Units    = r_units;
    assign Tens     = r_tens;
    assign Hundreds = r_hund;
    assign Zero     = r_zero;
    assign Overflow = r_overflow;

endmodule
`default_nettype wire
